// File: rtl/timer_int.sv
// ---------------------------------------------------------------------------
// timer_int
//   Memory-mapped machine timer for the peripheral bus. A prescaled 32-bit
//   up-counter is compared against VALUE. On a match the counter restarts
//   from zero and a sticky PEND flag is set. When enabled by IE, PEND drives
//   a level interrupt towards the core's int_flag_i vector (INT_TIMER0).
//
// Register map (addr_i[3:2]):
//   00 CTRL  bit0 EN, bit1 IE, bit2 PEND (read, write-1-to-clear)
//   01 COUNT 32-bit counter
//   10 VALUE 32-bit compare value
//   11 PSC   prescale, PRESCALE_W bits
//
// Ports:
//   clk        clock
//   rst        asynchronous reset, active-low
//   req_i      bus access request, one cycle per access
//   we_i       1 = write, 0 = read (qualified by req_i)
//   addr_i     byte address, only [3:2] decoded
//   data_i     write data
//   data_o     registered read data, 0 on writes and idle cycles
//   ack_o      access-complete pulse, one cycle after req_i
//   int_sig_o  registered interrupt level (PEND & IE)
// ---------------------------------------------------------------------------
module timer_int #(
  parameter int          PRESCALE_W = 8,
  parameter logic [31:0] VALUE_RST  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        int_sig_o
);

  localparam logic [1:0] ADDR_CTRL  = 2'b00;
  localparam logic [1:0] ADDR_COUNT = 2'b01;
  localparam logic [1:0] ADDR_VALUE = 2'b10;
  localparam logic [1:0] ADDR_PSC   = 2'b11;

  localparam logic [PRESCALE_W-1:0] PSC_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic                  r_en;
  logic                  r_ie;
  logic                  r_pend;
  logic [31:0]           r_count;
  logic [31:0]           r_value;
  logic [PRESCALE_W-1:0] r_psc;
  logic [PRESCALE_W-1:0] r_psc_cnt;
  logic [31:0]           r_data;
  logic                  r_ack;
  logic                  r_int;

  logic [1:0]  w_sel;
  logic        w_wr;
  logic        w_rd;
  logic        w_wr_ctrl;
  logic        w_wr_count;
  logic        w_wr_value;
  logic        w_wr_psc;
  logic        w_tick;
  logic        w_match;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_sel      = addr_i[3:2];
  assign w_wr       = req_i & we_i;
  assign w_rd       = req_i & ~we_i;
  assign w_wr_ctrl  = w_wr & (w_sel == ADDR_CTRL);
  assign w_wr_count = w_wr & (w_sel == ADDR_COUNT);
  assign w_wr_value = w_wr & (w_sel == ADDR_VALUE);
  assign w_wr_psc   = w_wr & (w_sel == ADDR_PSC);

  // Address bits outside [3:2] are deliberately ignored.
  assign w_unused = ^{addr_i[31:4], addr_i[1:0]};

  // One tick per (PSC+1) enabled cycles.
  assign w_tick  = r_en & (r_psc_cnt == r_psc);
  assign w_match = (r_count == r_value);

  // Read multiplexer; unimplemented bits read as zero.
  always_comb begin
    w_rdata = 32'd0;
    case (w_sel)
      ADDR_CTRL:  w_rdata = {29'd0, r_pend, r_ie, r_en};
      ADDR_COUNT: w_rdata = r_count;
      ADDR_VALUE: w_rdata = r_value;
      ADDR_PSC:   w_rdata = {{(32-PRESCALE_W){1'b0}}, r_psc};
      default:    w_rdata = 32'd0;
    endcase
  end

  // Bus response: ack one cycle after the request, data only for reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack  <= 1'b0;
      r_data <= 32'd0;
    end else begin
      r_ack  <= req_i;
      r_data <= w_rd ? w_rdata : 32'd0;
    end
  end

  // Control bits, compare value and prescale register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en    <= 1'b0;
      r_ie    <= 1'b0;
      r_value <= VALUE_RST;
      r_psc   <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_en <= data_i[0];
        r_ie <= data_i[1];
      end
      if (w_wr_value) begin
        r_value <= data_i;
      end
      if (w_wr_psc) begin
        r_psc <= data_i[PRESCALE_W-1:0];
      end
    end
  end

  // Prescale counter: restarts on a PSC write, holds while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_psc_cnt <= '0;
    end else if (w_wr_psc) begin
      r_psc_cnt <= '0;
    end else if (r_en) begin
      r_psc_cnt <= w_tick ? '0 : (r_psc_cnt + PSC_ONE);
    end
  end

  // Main counter: a software write beats the tick in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 32'd0;
    end else if (w_wr_count) begin
      r_count <= data_i;
    end else if (w_tick) begin
      r_count <= w_match ? 32'd0 : (r_count + 32'd1);
    end
  end

  // Sticky pending flag: a match outranks a simultaneous W1C so no
  // interrupt is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= 1'b0;
    end else if (w_tick && w_match) begin
      r_pend <= 1'b1;
    end else if (w_wr_ctrl && data_i[2]) begin
      r_pend <= 1'b0;
    end
  end

  // Interrupt level is registered, so it trails PEND/IE by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_int <= 1'b0;
    end else begin
      r_int <= r_pend & r_ie;
    end
  end

  assign data_o    = r_data;
  assign ack_o     = r_ack;
  assign int_sig_o = r_int;

endmodule

// File: tb/tb_timer_int.sv
// ---------------------------------------------------------------------------
// tb_timer_int
//   Directed testbench for timer_int. Each bus task spans exactly one rising
//   edge: inputs change on the falling edge, outputs are sampled 1 ns after
//   the rising edge. Expected values are hand-computed per vector.
// ---------------------------------------------------------------------------
module tb_timer_int;

  localparam logic [31:0] ADDR_CTRL  = 32'h0000_0000;
  localparam logic [31:0] ADDR_COUNT = 32'h0000_0004;
  localparam logic [31:0] ADDR_VALUE = 32'h0000_0008;
  localparam logic [31:0] ADDR_PSC   = 32'h0000_000C;

  logic        clk = 1'b0;
  logic        rstN;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wrData;
  logic [31:0] rdData;
  logic        ack;
  logic        intSig;

  int vectors     = 0;
  int miscompares = 0;

  timer_int #(
    .PRESCALE_W (8),
    .VALUE_RST  (32'hFFFF_FFFF)
  ) dut (
    .clk       (clk),
    .rst       (rstN),
    .req_i     (req),
    .we_i      (we),
    .addr_i    (addr),
    .data_i    (wrData),
    .data_o    (rdData),
    .ack_o     (ack),
    .int_sig_o (intSig)
  );

  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req    = r;
    we     = w;
    addr   = a;
    wrData = d;
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b1, a, d);
    checkOutput("wr ack", 32'(ack), 32'd1);
    checkOutput("wr data_o", rdData, 32'd0);
  endtask

  task automatic busReadCheck(input string tag, input logic [31:0] a,
                              input logic [31:0] expected);
    applyStimulus(1'b1, 1'b0, a, 32'd0);
    checkOutput("rd ack", 32'(ack), 32'd1);
    checkOutput(tag, rdData, expected);
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    end
  endtask

  logic [31:0] fireCount [6] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
  logic [31:0] fireInt   [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
  logic [31:0] pscCount  [7] = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd0};

  initial begin
    rstN   = 1'b0;
    req    = 1'b0;
    we     = 1'b0;
    addr   = 32'd0;
    wrData = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst ack", 32'(ack), 32'd0);
    checkOutput("rst data_o", rdData, 32'd0);
    checkOutput("rst int", 32'(intSig), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    busReadCheck("rst CTRL", ADDR_CTRL, 32'd0);
    busReadCheck("rst COUNT", ADDR_COUNT, 32'd0);
    busReadCheck("rst VALUE", ADDR_VALUE, 32'hFFFF_FFFF);
    busReadCheck("rst PSC", ADDR_PSC, 32'd0);
    idleCycles(1);
    checkOutput("idle ack", 32'(ack), 32'd0);
    checkOutput("idle data_o", rdData, 32'd0);
    checkOutput("rst int2", 32'(intSig), 32'd0);

    // Basic fire: PSC=0, VALUE=4, EN+IE; COUNT 0..4 then wraps
    busWrite(ADDR_PSC, 32'd0);
    busWrite(ADDR_VALUE, 32'd4);
    busWrite(ADDR_CTRL, 32'd3);
    for (int i = 0; i < 6; i++) begin
      busReadCheck("fire COUNT", ADDR_COUNT, fireCount[i]);
      checkOutput("fire int", 32'(intSig), fireInt[i]);
    end

    // Clearing IE drops the interrupt, PEND stays; EN=0 freezes COUNT
    busWrite(ADDR_CTRL, 32'd0);
    idleCycles(1);
    checkOutput("ie off int", 32'(intSig), 32'd0);
    busReadCheck("ie off CTRL", ADDR_CTRL, 32'd4);
    busReadCheck("hold COUNT a", ADDR_COUNT, 32'd2);
    idleCycles(20);
    busReadCheck("hold COUNT b", ADDR_COUNT, 32'd2);
    busWrite(ADDR_CTRL, 32'd2);
    idleCycles(1);
    checkOutput("ie on int", 32'(intSig), 32'd1);
    busWrite(ADDR_CTRL, 32'd6);
    idleCycles(2);
    checkOutput("w1c int", 32'(intSig), 32'd0);
    busReadCheck("w1c CTRL", ADDR_CTRL, 32'd2);

    // Prescale: PSC=2, VALUE=1; one tick per 3 cycles, PEND after 6
    busWrite(ADDR_PSC, 32'd2);
    busWrite(ADDR_VALUE, 32'd1);
    busWrite(ADDR_COUNT, 32'd0);
    busWrite(ADDR_CTRL, 32'd1);
    for (int i = 0; i < 7; i++) begin
      busReadCheck("psc COUNT", ADDR_COUNT, pscCount[i]);
    end
    busReadCheck("psc CTRL", ADDR_CTRL, 32'd5);
    busWrite(ADDR_CTRL, 32'd4);
    busReadCheck("psc clr CTRL", ADDR_CTRL, 32'd0);
    checkOutput("psc int", 32'(intSig), 32'd0);

    // Clear race: VALUE=0 matches every tick; W1C on a match cycle loses
    busWrite(ADDR_PSC, 32'd0);
    busWrite(ADDR_VALUE, 32'd0);
    busWrite(ADDR_COUNT, 32'd0);
    busWrite(ADDR_CTRL, 32'd3);
    busWrite(ADDR_CTRL, 32'd7);
    busReadCheck("race CTRL", ADDR_CTRL, 32'd7);
    checkOutput("race int", 32'(intSig), 32'd1);
    idleCycles(1);
    checkOutput("race int2", 32'(intSig), 32'd1);
    busWrite(ADDR_CTRL, 32'd4);
    busWrite(ADDR_CTRL, 32'd4);
    busReadCheck("race off CTRL", ADDR_CTRL, 32'd0);
    busReadCheck("race COUNT", ADDR_COUNT, 32'd0);
    checkOutput("race off int", 32'(intSig), 32'd0);

    // COUNT write in a tick cycle wins over the increment
    busWrite(ADDR_VALUE, 32'd1000);
    busWrite(ADDR_CTRL, 32'd1);
    idleCycles(3);
    busWrite(ADDR_COUNT, 32'd100);
    busReadCheck("prio COUNT a", ADDR_COUNT, 32'd100);
    busReadCheck("prio COUNT b", ADDR_COUNT, 32'd101);
    busWrite(ADDR_CTRL, 32'd0);

    // Back-to-back reads with ignored address bits set
    busWrite(ADDR_COUNT, 32'h1234_5678);
    busWrite(ADDR_VALUE, 32'hCAFE_F00D);
    busWrite(ADDR_PSC, 32'hFFFF_FFA5);
    busWrite(ADDR_CTRL, 32'hFFFF_FFF8);
    busReadCheck("b2b CTRL", 32'hABCD_0003, 32'd0);
    busReadCheck("b2b COUNT", 32'hFFFF_FF06, 32'h1234_5678);
    busReadCheck("b2b VALUE", 32'h0000_00F9, 32'hCAFE_F00D);
    busReadCheck("b2b PSC", 32'h8000_000F, 32'h0000_00A5);
    idleCycles(1);
    checkOutput("b2b idle ack", 32'(ack), 32'd0);

    // Reset during an access
    applyStimulus(1'b1, 1'b0, ADDR_COUNT, 32'd0);
    checkOutput("pre-rst ack", 32'(ack), 32'd1);
    checkOutput("pre-rst data", rdData, 32'h1234_5678);
    rstN = 1'b0;
    #1;
    checkOutput("async rst ack", 32'(ack), 32'd0);
    checkOutput("async rst data", rdData, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("mid-req rst ack", 32'(ack), 32'd0);
    @(negedge clk);
    req  = 1'b0;
    rstN = 1'b1;
    busReadCheck("post-rst VALUE", ADDR_VALUE, 32'hFFFF_FFFF);
    busReadCheck("post-rst COUNT", ADDR_COUNT, 32'd0);
    busReadCheck("post-rst PSC", ADDR_PSC, 32'd0);
    busReadCheck("post-rst CTRL", ADDR_CTRL, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
